// File: rtl/adc_fft_if_fifo_pkg.sv
// Shared constants and helpers for the ADC-to-FFT sample FIFO.
package adc_fft_if_fifo_pkg;

  localparam int PIPE_NONE        = 0;
  localparam int PIPE_OUT         = 1;
  localparam int DEF_AEMPTY_TH    = 4;
  localparam int DEF_AFULL_MARGIN = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/adc_fft_if_fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered synchronous read port.
module adc_fft_if_fifo_dpram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  // Only the read register is reset so RDATA starts at zero; the array stays uninitialised.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)     r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];

  assign o_rdata = r_q;

endmodule

// File: rtl/adc_fft_if_sync_fifo.sv
// Single-clock FIFO for the ADC-to-FFT path: pointer/flag control, RAM and read pipeline.
module adc_fft_if_sync_fifo
  import adc_fft_if_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int AW        = clog2(DEPTH),
  parameter int PIPE      = PIPE_OUT,
  parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             WEN,
  input  logic             REN,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [AW:0]      COUNT
);

  localparam logic [AW:0] L_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_AFULL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] L_AEMPTY = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] L_ONE    = (AW+1)'(1);

  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count, w_cnt_nxt;
  logic             r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic [PIPE:0]    r_vld_pipe;
  logic             w_wr_acc, w_rd_acc;
  logic [WIDTH-1:0] w_ram_q;

  assign w_wr_acc = WEN & ~r_full;
  assign w_rd_acc = REN & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = r_count + L_ONE;
    else if (!w_wr_acc && w_rd_acc) w_cnt_nxt = r_count - L_ONE;
  end

  // Flags come from the next count so they track COUNT in the same cycle.
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == L_DEPTH);
      r_empty  <= (w_cnt_nxt == '0);
      r_afull  <= (w_cnt_nxt >= L_AFULL);
      r_aempty <= (w_cnt_nxt <= L_AEMPTY);
      r_ovf    <= WEN & r_full;
      r_unf    <= REN & r_empty;
    end

  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[0] <= w_rd_acc;
      for (int i = 1; i <= PIPE; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end

  adc_fft_if_fifo_dpram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (CLOCK),
    .i_rst   (RESET),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (WDATA),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_q)
  );

  generate
    if (PIPE == PIPE_NONE) begin : g_nopipe
      assign RDATA = w_ram_q;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge CLOCK or posedge RESET)
        if (RESET)              r_dout <= '0;
        else if (r_vld_pipe[0]) r_dout <= w_ram_q;
      assign RDATA = r_dout;
    end
  endgenerate

  assign RVALID    = r_vld_pipe[PIPE];
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign AFULL     = r_afull;
  assign AEMPTY    = r_aempty;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_unf;
  assign COUNT     = r_count;

endmodule

// File: tb/tb_adc_fft_if_sync_fifo.sv
// Self-checking bench: queue-based FIFO reference with a fixed read-latency delay line.
module tb_adc_fft_if_sync_fifo;

  localparam int W = 16, D = 8, AWT = 3, PIPE = 1, AFT = 4, AET = 2;
  localparam int LAT = PIPE + 1;

  logic           CLOCK = 1'b0, RESET = 1'b0, WEN = 1'b0, REN = 1'b0;
  logic [W-1:0]   WDATA = '0;
  logic [W-1:0]   RDATA;
  logic           RVALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
  logic [AWT:0]   COUNT;

  adc_fft_if_sync_fifo #(.WIDTH(W), .DEPTH(D), .PIPE(PIPE), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .WDATA(WDATA), .WEN(WEN), .REN(REN), .RDATA(RDATA),
    .RVALID(RVALID), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .COUNT(COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0, n_err = 0, cyc = 0;

  // Reference: contents queue plus in-flight reads tagged with the cycle they appear.
  logic [W-1:0] m_q[$];
  int           rd_due[$];
  logic [W-1:0] rd_dat[$];
  logic         m_rv = 0, m_ovf = 0, m_unf = 0;
  logic [W-1:0] m_rd = '0;

  function automatic logic [10:0] exp_stat();
    int n = m_q.size();
    return {4'(n), n == D, n == 0, n >= AFT, n <= AET, m_ovf, m_unf, m_rv};
  endfunction

  function automatic logic [10:0] act_stat();
    return {COUNT, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW, RVALID};
  endfunction

  // Drive one clock edge and advance the reference; sampling happens #1 after the edge.
  task automatic step(input bit wen, input bit ren, input logic [W-1:0] d);
    bit full, empty;
    WEN = wen; REN = ren; WDATA = d;
    @(posedge CLOCK);
    full  = (m_q.size() == D);
    empty = (m_q.size() == 0);
    m_ovf = wen && full;
    m_unf = ren && empty;
    cyc++;
    if (ren && !empty) begin
      rd_due.push_back(cyc + LAT - 1);
      rd_dat.push_back(m_q.pop_front());
    end
    if (wen && !full) m_q.push_back(d);
    m_rv = 1'b0;
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      m_rv = 1'b1;
      m_rd = rd_dat.pop_front();
      void'(rd_due.pop_front());
    end
    #1;
  endtask

  task automatic model_reset();
    m_q.delete(); rd_due.delete(); rd_dat.delete();
    m_rv = 0; m_ovf = 0; m_unf = 0; m_rd = '0;
  endtask

  task automatic test_reset();
    WEN = 0; REN = 0; RESET = 1'b1;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #2;
    n_chk++;
    if (act_stat() !== 11'b0000_0101_000)
      begin n_err++; $display("FAIL reset_status act=%h exp=%h", act_stat(), 11'b0000_0101_000); end
    n_chk++;
    if (RDATA !== '0) begin n_err++; $display("FAIL reset_rdata act=%h exp=0", RDATA); end
    @(negedge CLOCK); RESET = 1'b0; #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] wd[3] = '{16'h11, 16'h22, 16'h33};
    for (int i = 0; i < 9; i++) begin
      if (i < 3)      step(1, 0, wd[i]);
      else if (i < 6) step(0, 1, '0);
      else            step(0, 0, '0);
      n_chk++;
      if (act_stat() !== exp_stat())
        begin n_err++; $display("FAIL basic_status cyc=%0d act=%h exp=%h", i, act_stat(), exp_stat()); end
      n_chk++;
      if (RDATA !== m_rd) begin n_err++; $display("FAIL basic_rdata cyc=%0d act=%h exp=%h", i, RDATA, m_rd); end
    end
    n_chk++;
    if (!(EMPTY === 1'b1 && COUNT === '0 && m_rd === 16'h33))
      begin n_err++; $display("FAIL basic_final empty=%b count=%0d rdata=%h exp 1/0/33", EMPTY, COUNT, RDATA); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 16'hA0 + 16'(i));
      n_chk++;
      if (act_stat() !== exp_stat())
        begin n_err++; $display("FAIL full_status w=%0d act=%h exp=%h", i, act_stat(), exp_stat()); end
    end
    n_chk++;
    if (!(OVERFLOW === 1'b1 && FULL === 1'b1 && COUNT === 4'd8))
      begin n_err++; $display("FAIL overflow ovf=%b full=%b count=%0d exp 1/1/8", OVERFLOW, FULL, COUNT); end
    step(0, 0, '0);
    n_chk++;
    if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL overflow_pulse act=%b exp=0", OVERFLOW); end
    // Simultaneous read/write while full: oldest word out, write dropped.
    step(1, 1, 16'hEE);
    n_chk++;
    if (!(OVERFLOW === 1'b1 && COUNT === 4'd7))
      begin n_err++; $display("FAIL full_wr_rd ovf=%b count=%0d exp 1/7", OVERFLOW, COUNT); end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, '0);
      n_chk++;
      if (act_stat() !== exp_stat())
        begin n_err++; $display("FAIL drain_status i=%0d act=%h exp=%h", i, act_stat(), exp_stat()); end
      n_chk++;
      if (RDATA !== m_rd) begin n_err++; $display("FAIL drain_rdata i=%0d act=%h exp=%h", i, RDATA, m_rd); end
    end
  endtask

  task automatic test_underflow();
    repeat (2) step(0, 0, '0);
    step(0, 1, '0);
    n_chk++;
    if (!(UNDERFLOW === 1'b1 && RVALID === 1'b0 && COUNT === '0))
      begin n_err++; $display("FAIL underflow unf=%b rv=%b count=%0d exp 1/0/0", UNDERFLOW, RVALID, COUNT); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0);
      n_chk++;
      if (act_stat() !== exp_stat())
        begin n_err++; $display("FAIL underflow_after i=%0d act=%h exp=%h", i, act_stat(), exp_stat()); end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 16'h100);
    n_chk++;
    if (!(UNDERFLOW === 1'b1 && COUNT === 4'd1))
      begin n_err++; $display("FAIL empty_wr_rd unf=%b count=%0d exp 1/1", UNDERFLOW, COUNT); end
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 16'h100 + 16'(i));
      n_chk++;
      if (act_stat() !== exp_stat())
        begin n_err++; $display("FAIL b2b_status i=%0d act=%h exp=%h", i, act_stat(), exp_stat()); end
      n_chk++;
      if (RDATA !== m_rd) begin n_err++; $display("FAIL b2b_rdata i=%0d act=%h exp=%h", i, RDATA, m_rd); end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, i == 0, '0);
      n_chk++;
      if (RDATA !== m_rd || RVALID !== m_rv)
        begin n_err++; $display("FAIL b2b_tail i=%0d act=%b/%h exp=%b/%h", i, RVALID, RDATA, m_rv, m_rd); end
    end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 4; i++) step(1, 0, 16'h50 + 16'(i));
    step(0, 1, '0);
    step(0, 1, '0);
    RESET = 1'b1; WEN = 0; REN = 0;
    model_reset();
    #1;
    n_chk++;
    if (!(RVALID === 1'b0 && EMPTY === 1'b1 && COUNT === '0))
      begin n_err++; $display("FAIL midburst_reset rv=%b empty=%b count=%0d exp 0/1/0", RVALID, EMPTY, COUNT); end
    @(posedge CLOCK); @(negedge CLOCK); RESET = 1'b0;
    step(1, 0, 16'hAB);
    step(0, 1, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0);
      n_chk++;
      if (act_stat() !== exp_stat() || RDATA !== m_rd)
        begin n_err++; $display("FAIL post_reset i=%0d act=%h/%h exp=%h/%h", i, act_stat(), RDATA, exp_stat(), m_rd); end
    end
    n_chk++;
    if (RDATA !== 16'hAB) begin n_err++; $display("FAIL post_reset_data act=%h exp=ab", RDATA); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 100) < 55, ($urandom % 100) < 45, 16'($urandom));
      n_chk++;
      if (act_stat() !== exp_stat())
        begin n_err++; $display("FAIL rand_status i=%0d act=%h exp=%h", i, act_stat(), exp_stat()); end
      n_chk++;
      if (RDATA !== m_rd) begin n_err++; $display("FAIL rand_rdata i=%0d act=%h exp=%h", i, RDATA, m_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_fft_if_sync_fifo.md
Name: adc_fft_if_sync_fifo

Overview:
Single-clock parametrised FIFO for the ADC-to-FFT sample path. It combines the pointer/flag controller and a dual-port RAM, so no external address generation is needed. Compared with the current LSRAM wrapper it adds:
- configurable width and depth;
- a selectable read pipeline depth;
- almost-full/almost-empty thresholds;
- overflow/underflow reporting and an occupancy count.

It sits between the ADC sample packer and the FFT input loader.

Parameters:
WIDTH, 32, data width in bits (1..64)
DEPTH, 128, number of entries; power of two, 4..4096
AW, clog2(DEPTH), address width (derived, do not override)
PIPE, 1, 0 = RDATA 1 cycle after accepted read; 1 = extra output register, 2 cycles
AFULL_TH, DEPTH-4, AFULL asserted when COUNT >= AFULL_TH
AEMPTY_TH, 4, AEMPTY asserted when COUNT <= AEMPTY_TH

Ports:
CLOCK  in  1  sole clock; all logic rising-edge
RESET  in  1  asynchronous, active-high reset
WDATA  in  WIDTH  write data
WEN  in  1  write request
REN  in  1  read request
RDATA  out  WIDTH  read data
RVALID  out  1  RDATA holds data of an accepted read this cycle
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
AFULL  out  1  almost full
AEMPTY  out  1  almost empty
OVERFLOW  out  1  one-cycle pulse: WEN while FULL (write dropped)
UNDERFLOW  out  1  one-cycle pulse: REN while EMPTY (read dropped)
COUNT  out  AW+1  current occupancy

Behaviour:
- Interface: one clock (CLOCK); reset RESET is asynchronous and active-high.
- Reset values:
  - wptr = rptr = 0, COUNT = 0.
  - EMPTY = 1, AEMPTY = 1.
  - FULL = AFULL = 0.
  - RDATA = 0, RVALID = 0.
  - OVERFLOW = UNDERFLOW = 0.
  - Pipeline valid bits cleared.
  - RAM contents are not reset.
- Accept rules, evaluated on registered flags at the edge:
  - wr_acc = WEN & ~FULL.
  - rd_acc = REN & ~EMPTY.
  - Simultaneous WEN+REN when FULL: read accepted, write dropped, OVERFLOW pulses.
  - Simultaneous WEN+REN when EMPTY: write accepted, read dropped, UNDERFLOW pulses.
  - No bypass of written data to the read port.
- Pointers:
  - AW-bit wptr/rptr, increment by 1 on accept, natural wrap DEPTH-1 -> 0.
  - COUNT += wr_acc - rd_acc; both accepted leaves COUNT unchanged.
- Flags: all registered and derived from next-COUNT, so they are valid in the same cycle COUNT updates.
  - FULL = (next == DEPTH); EMPTY = (next == 0).
  - AFULL = (next >= AFULL_TH); AEMPTY = (next <= AEMPTY_TH).
- Read latency:
  - RAM read is synchronous; address rptr is captured on rd_acc.
  - PIPE=0: RDATA/RVALID valid the cycle after the accepting edge.
  - PIPE=1: one further register stage, valid 2 cycles after.
  - RVALID is high exactly one cycle per accepted read.
  - RDATA holds its last value when RVALID = 0.
- Back-to-back reads give one word per cycle with no bubbles. The pipeline is never stalled; the consumer must take RVALID data.
- OVERFLOW and UNDERFLOW are registered pulses, high for one cycle per dropped request. They are not sticky.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously), including in-flight pipeline data.
  - First accept possible at the first edge after RESET deasserts.
- Write to the RAM occurs at the accepting edge. Data written at edge N is readable by an rd_acc at edge N+1 or later.

Decomposition:
- Package adc_fft_if_fifo_pkg:
  - clog2 function;
  - PIPE encoding constants (PIPE_NONE = 0, PIPE_OUT = 1);
  - default threshold constants.
- Sub-module adc_fft_if_fifo_dpram: simple dual-port RAM with WIDTH×DEPTH, one write port and one synchronous read port (registered RD), inferable as LSRAM/uSRAM.
- Controller, flags, counters and output pipeline live in the top module.

Test Plan:
1. Reset, then write 0x11,0x22,0x33 on consecutive cycles, then REN×3 with PIPE=1 -> RVALID high on cycles rd+2..rd+4, RDATA 0x11,0x22,0x33; EMPTY=1, COUNT=0 afterwards.
2. DEPTH=8: write 8 words -> FULL=1, COUNT=8, AFULL=1 (AFULL_TH=4 at 4 words). A 9th WEN -> OVERFLOW pulse, COUNT stays 8, data unchanged on readback.
3. REN while EMPTY -> UNDERFLOW one-cycle pulse, RVALID stays 0, COUNT stays 0.
4. COUNT=8 (FULL), WEN+REN in the same cycle -> read returns the oldest word, write dropped, OVERFLOW=1, COUNT=7.
5. COUNT=0, WEN+REN in the same cycle -> write accepted, UNDERFLOW=1, COUNT=1. Then 20 cycles of WEN+REN with counting data -> COUNT constant at 1, pointers wrap, reads return data in order.
6. Assert RESET mid-burst with 2 reads in the PIPE=1 pipeline -> RVALID=0 immediately, EMPTY=1, COUNT=0. After release, write 0xAB then read -> RDATA=0xAB.
